div_unit: RTL and testbench



---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 20 ++
 rtl/div_unit.sv | 201 ++++++++++++++++++++
 tb/tb_div_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the multi-cycle divider.
// Imported by the divider RTL and visible to microcode tables.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    DIVIDE,
    FIXUP,
    DONE
  } div_state_t;

  localparam int DIV_COUNT_BITS = 5;

  // INT 0 vector raised by microcode on a divide error.
  localparam logic [7:0] DIV_ERR_VECTOR = 8'h00;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
// The compare is 17 bits wide so the bit shifted out of rem_i is kept.
module div_step (
  input  logic [15:0] rem_i,
  input  logic [15:0] dsr_i,
  input  logic        bit_i,
  output logic [15:0] rem_o,
  output logic        q_o
);

  logic [16:0] shifted;

  // shift in next dividend bit, trial-subtract, restore on borrow
  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = (shifted >= {1'b0, dsr_i});
    rem_o   = q_o ? (shifted[15:0] - dsr_i) : shifted[15:0];
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: restoring DIV/IDIV engine, 32/16 and 16/8.
// One quotient bit per cycle; signs applied after the magnitude loop.
module div_unit
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_8_bit,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        complete,
  output logic        error,
  output logic [15:0] quotient,
  output logic [15:0] remainder
);

  div_state_t state_q, state_d;

  logic        busy_q, busy_d;
  logic        complete_q, complete_d;
  logic        error_q, error_d;
  logic [15:0] quotient_q, quotient_d;
  logic [15:0] remainder_q, remainder_d;

  logic        is8_q, is8_d;
  logic        sgn_q, sgn_d;
  logic [31:0] dvd_q, dvd_d;
  logic [15:0] dsr_q, dsr_d;
  logic [15:0] prem_q, prem_d;
  logic [15:0] quo_q, quo_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  logic [DIV_COUNT_BITS-1:0] cnt_q, cnt_d;

  logic        dvd_neg, dsr_neg;
  logic [31:0] dvd_ext, dvd_inv, dvd_mag;
  logic [15:0] dsr_ext, dsr_inv, dsr_mag;
  logic [15:0] hi_mag, lo_mag;
  logic [15:0] q_sgn, r_sgn, q_fix, r_fix;
  logic [15:0] q_limit;
  logic        range_err;

  logic [15:0] step_rem;
  logic        step_q;

  div_step u_step (
    .rem_i (prem_q),
    .dsr_i (dsr_q),
    .bit_i (quo_q[15]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // operand magnitudes and signed result fixup
  always_comb begin
    dvd_neg = sgn_q & (is8_q ? dvd_q[15] : dvd_q[31]);
    dsr_neg = sgn_q & (is8_q ? dsr_q[7] : dsr_q[15]);
    dvd_ext = is8_q ? {16'h0, dvd_q[15:0]} : dvd_q;
    dsr_ext = is8_q ? {8'h0, dsr_q[7:0]} : dsr_q;
    dvd_inv = dvd_neg ? (32'h0 - dvd_ext) : dvd_ext;
    dsr_inv = dsr_neg ? (16'h0 - dsr_ext) : dsr_ext;
    dvd_mag = is8_q ? {16'h0, dvd_inv[15:0]} : dvd_inv;
    dsr_mag = is8_q ? {8'h0, dsr_inv[7:0]} : dsr_inv;
    hi_mag  = is8_q ? {8'h0, dvd_mag[15:8]} : dvd_mag[31:16];
    // 8-bit low half is left-aligned so quo_q[15] is always the next bit
    lo_mag  = is8_q ? {dvd_mag[7:0], 8'h0} : dvd_mag[15:0];

    q_sgn     = qneg_q ? (16'h0 - quo_q) : quo_q;
    r_sgn     = rneg_q ? (16'h0 - prem_q) : prem_q;
    q_fix     = is8_q ? {8'h0, q_sgn[7:0]} : q_sgn;
    r_fix     = is8_q ? {8'h0, r_sgn[7:0]} : r_sgn;
    q_limit   = is8_q ? 16'h007F : 16'h7FFF;
    range_err = sgn_q & (quo_q > q_limit);
  end

  // next-state and datapath control
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    complete_d  = 1'b0;
    error_d     = error_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    is8_d       = is8_q;
    sgn_d       = sgn_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          state_d = PREP;
          busy_d  = 1'b1;
          error_d = 1'b0;
          is8_d   = is_8_bit;
          sgn_d   = is_signed;
          dvd_d   = dividend;
          dsr_d   = divisor;
        end
      end
      PREP: begin
        dsr_d  = dsr_mag;
        qneg_d = dvd_neg ^ dsr_neg;
        rneg_d = dvd_neg;
        if ((dsr_mag == 16'h0) || (hi_mag >= dsr_mag)) begin
          error_d     = 1'b1;
          quotient_d  = 16'h0;
          remainder_d = 16'h0;
          busy_d      = 1'b0;
          complete_d  = 1'b1;
          state_d     = DONE;
        end else begin
          prem_d  = hi_mag;
          quo_d   = lo_mag;
          cnt_d   = is8_q ? 5'd8 : 5'd16;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        prem_d = step_rem;
        quo_d  = {quo_q[14:0], step_q};
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        if (range_err) begin
          error_d     = 1'b1;
          quotient_d  = 16'h0;
          remainder_d = 16'h0;
        end else begin
          quotient_d  = q_fix;
          remainder_d = r_fix;
        end
        busy_d     = 1'b0;
        complete_d = 1'b1;
        state_d    = DONE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // all state, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      complete_q  <= 1'b0;
      error_q     <= 1'b0;
      quotient_q  <= 16'h0;
      remainder_q <= 16'h0;
      is8_q       <= 1'b0;
      sgn_q       <= 1'b0;
      dvd_q       <= 32'h0;
      dsr_q       <= 16'h0;
      prem_q      <= 16'h0;
      quo_q       <= 16'h0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      complete_q  <= complete_d;
      error_q     <= error_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      is8_q       <= is8_d;
      sgn_q       <= sgn_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy      = busy_q;
  assign complete  = complete_q;
  assign error     = error_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed bench for div_unit.
// Expected results are queued at issue and popped on complete.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        is_8_bit;
  logic        is_signed;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        complete;
  logic        error;
  logic [15:0] quotient;
  logic [15:0] remainder;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        e;
    int          c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   comp_cnt = 0;
  int   pushed   = 0;

  div_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .is_8_bit  (is_8_bit),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .complete  (complete),
    .error     (error),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: every complete pulse must match the oldest expectation
  always @(negedge clk) begin
    if (complete === 1'b1) begin
      comp_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_complete observed=cycle%0d expected=none", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("complete_cycle", cyc, mon_e.c);
        chk("quotient", {16'h0, quotient}, {16'h0, mon_e.q});
        chk("remainder", {16'h0, remainder}, {16'h0, mon_e.r});
        chk("error", {31'h0, error}, {31'h0, mon_e.e});
        chk("busy_at_complete", {31'h0, busy}, 32'h0);
      end
    end
  end

  task automatic push(input logic [15:0] q, input logic [15:0] r,
                      input logic e, input int c);
    sb.push_back('{q: q, r: r, e: e, c: c});
    pushed++;
  endtask

  task automatic issue(input bit b8, input bit sg, input logic [31:0] dvd,
                       input logic [15:0] dsr, input logic [15:0] eq,
                       input logic [15:0] er, input bit ee, input int lat);
    @(posedge clk);
    #1;
    start     = 1'b1;
    is_8_bit  = b8;
    is_signed = sg;
    dividend  = dvd;
    divisor   = dsr;
    push(eq, er, ee, cyc + lat);
    @(posedge clk);
    #1;
    start     = 1'b0;
    is_8_bit  = 1'($urandom_range(0, 1));
    is_signed = 1'($urandom_range(0, 1));
    dividend  = $urandom;
    divisor   = 16'($urandom);
    @(negedge clk);
    chk("busy_cycle1", {31'h0, busy}, 32'h1);
    chk("error_cleared", {31'h0, error}, 32'h0);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL timeout observed=pending%0d expected=pending0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    is_8_bit  = 1'b0;
    is_signed = 1'b0;
    dividend  = 32'h0;
    divisor   = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_complete", {31'h0, complete}, 32'h0);
    chk("rst_error", {31'h0, error}, 32'h0);
    chk("rst_quotient", {16'h0, quotient}, 32'h0);
    chk("rst_remainder", {16'h0, remainder}, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    issue(0, 0, 32'h0001_0000, 16'h0003, 16'h5555, 16'h0001, 0, 19);
    wait_idle(40);
    issue(1, 0, 32'hABCD_00FF, 16'hEE10, 16'h000F, 16'h000F, 0, 11);
    wait_idle(40);
    issue(0, 1, 32'hFFFF_FFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 0, 19);
    wait_idle(40);
    issue(0, 1, 32'h0000_0007, 16'hFFFE, 16'hFFFD, 16'h0001, 0, 19);
    wait_idle(40);
    issue(0, 1, 32'hFFFF_FFF8, 16'h0002, 16'hFFFC, 16'h0000, 0, 19);
    wait_idle(40);
    issue(1, 1, 32'h1234_FF9C, 16'hAB07, 16'h00F2, 16'h00FE, 0, 11);
    wait_idle(40);

    issue(0, 0, 32'h1234_5678, 16'h0000, 16'h0000, 16'h0000, 1, 2);
    wait_idle(40);
    issue(0, 0, 32'h0002_0000, 16'h0001, 16'h0000, 16'h0000, 1, 2);
    wait_idle(40);
    issue(1, 1, 32'h0000_FF80, 16'h0001, 16'h0000, 16'h0000, 1, 11);
    wait_idle(40);
    issue(0, 1, 32'hFFFF_8000, 16'h0001, 16'h0000, 16'h0000, 1, 19);
    wait_idle(40);

    // start held through an op: second op accepted in the complete cycle
    @(posedge clk);
    #1;
    start     = 1'b1;
    is_8_bit  = 1'b0;
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 16'd7;
    push(16'd142, 16'd6, 0, cyc + 19);
    @(posedge clk);
    #1;
    dividend = 32'h0000_1234;
    divisor  = 16'h0010;
    push(16'h0123, 16'h0004, 0, cyc + 37);
    repeat (19) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(60);

    // stray start pulses while busy are dropped
    issue(0, 0, 32'd50000, 16'd300, 16'd166, 16'd200, 0, 19);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(40);
    repeat (25) @(posedge clk);
    #1;

    // reset in cycle 6 aborts without a complete pulse
    start     = 1'b1;
    is_8_bit  = 1'b0;
    is_signed = 1'b0;
    dividend  = 32'h0000_9999;
    divisor   = 16'h0003;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_complete", {31'h0, complete}, 32'h0);
    chk("abort_error", {31'h0, error}, 32'h0);
    chk("abort_quotient", {16'h0, quotient}, 32'h0);
    chk("abort_remainder", {16'h0, remainder}, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;

    issue(1, 0, 32'h0000_00C8, 16'h0007, 16'h001C, 16'h0004, 0, 11);
    wait_idle(40);
    repeat (25) @(posedge clk);
    chk("complete_count", comp_cnt, pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
